// File: rtl/ahb_mem_arbiter.sv
// ahb_mem_arbiter: arbitrates IF and LS requesters onto one AHB-lite path to ROM (HSEL1) and RAM (HSEL2).
// Build option ARB_ROUND_ROBIN_EN: strict alternation on contention instead of LS priority with starvation guard.
module ahb_mem_arbiter #(
  parameter logic [31:0] ROM_BASE   = 32'h0000_0000,
  parameter logic [31:0] ROM_SIZE   = 32'h0000_1000,
  parameter logic [31:0] RAM_BASE   = 32'h1000_0000,
  parameter logic [31:0] RAM_SIZE   = 32'h0000_1000,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_write,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [2:0]  ls_size,
  input  logic        ls_signed,
  output logic        ls_gnt,
  output logic [31:0] ls_rdata,
  output logic        ls_valid,
  output logic        ls_err,
  output logic        HSEL1,
  output logic        HSEL2,
  output logic        muxsel,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic        is_signed,
  input  logic [31:0] instruction,
  input  logic [31:0] load_out,
  input  logic        hready_inst,
  input  logic        hready_data,
  input  logic        hresp_inst,
  input  logic        hresp_data
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_ERR = 2'd3;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [1:0]  state_q, state_d;
  logic        own_ls_q, bad_q;
  logic [31:0] wdata_q, addr_sel, rdata_sel;
  logic        pick_ls, rom_hit, ram_hit, misalign, bad, ready, done;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_ls_q;
  assign pick_ls = ls_req & (~if_req | ~last_ls_q);
`else
  logic [3:0]  starve_q;
  assign pick_ls = ls_req & (~if_req | (starve_q != SMAX));
`endif
  assign addr_sel  = pick_ls ? ls_addr : if_addr;
  assign rom_hit   = (addr_sel & ~(ROM_SIZE - 32'd1)) == ROM_BASE;
  assign ram_hit   = (addr_sel & ~(RAM_SIZE - 32'd1)) == RAM_BASE;
  assign misalign  = (ls_size == 3'd1 & ls_addr[0]) | (ls_size == 3'd2 & |ls_addr[1:0]) | (ls_size > 3'd2);
  assign bad       = ~(rom_hit | ram_hit) | (pick_ls & (misalign | (ls_write & rom_hit)));
  assign ready     = HSEL2 ? hready_data : hready_inst;
  assign done      = (state_q == S_DATA & ready) | state_q == S_ERR;
  assign rdata_sel = bad_q ? 32'd0 : (muxsel ? load_out : instruction);
  // Next state: one address cycle, then a data phase that waits on the selected slave, or a one-cycle error
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = (if_req | ls_req) ? S_ADDR : S_IDLE;
      S_ADDR:  state_d = bad_q ? S_ERR : S_DATA;
      S_DATA:  state_d = ready ? S_IDLE : S_DATA;
      default: state_d = S_IDLE;
    endcase
  end
  // Registered bus outputs: latched at grant, hwdata added for the data phase, all cleared on completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      own_ls_q  <= 1'b0;
      bad_q     <= 1'b0;
      wdata_q   <= '0;
      if_gnt    <= 1'b0;
      ls_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      ls_valid  <= 1'b0;
      if_err    <= 1'b0;
      ls_err    <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      HSEL1     <= 1'b0;
      HSEL2     <= 1'b0;
      muxsel    <= 1'b0;
      haddr     <= '0;
      hwdata    <= '0;
      hwrite    <= 1'b0;
      hsize     <= '0;
      hprot     <= '0;
      is_signed <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_ls_q <= 1'b0;
`else
      starve_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      if_gnt   <= 1'b0;
      ls_gnt   <= 1'b0;
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      if_err   <= 1'b0;
      ls_err   <= 1'b0;
      if (state_q == S_IDLE && (if_req | ls_req)) begin
        own_ls_q  <= pick_ls;
        bad_q     <= bad;
        wdata_q   <= ls_wdata;
        if_gnt    <= ~pick_ls;
        ls_gnt    <= pick_ls;
        HSEL1     <= ~bad & rom_hit;
        HSEL2     <= ~bad & ram_hit;
        muxsel    <= ~bad & ram_hit;
        haddr     <= addr_sel;
        hwrite    <= pick_ls & ls_write;
        hsize     <= pick_ls ? ls_size : 3'd2;
        hprot     <= {3'b000, pick_ls};
        is_signed <= pick_ls & ls_signed;
`ifdef ARB_ROUND_ROBIN_EN
        last_ls_q <= pick_ls;
`else
        if (!pick_ls) starve_q <= '0;
        else if (if_req) starve_q <= starve_q + 4'd1;
`endif
      end
      if (state_q == S_ADDR && !bad_q) hwdata <= wdata_q;
      if (done) begin
        if_valid  <= ~own_ls_q;
        ls_valid  <= own_ls_q;
        if_err    <= ~own_ls_q & (bad_q | (HSEL2 ? hresp_data : hresp_inst));
        ls_err    <= own_ls_q & (bad_q | (HSEL2 ? hresp_data : hresp_inst));
        if (own_ls_q) ls_rdata <= rdata_sel;
        else if_rdata <= rdata_sel;
        HSEL1     <= 1'b0;
        HSEL2     <= 1'b0;
        muxsel    <= 1'b0;
        haddr     <= '0;
        hwdata    <= '0;
        hwrite    <= 1'b0;
        hsize     <= '0;
        hprot     <= '0;
        is_signed <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// tb_ahb_mem_arbiter: directed table, randomized transaction model and multi-cycle corner sequences.
module tb_ahb_mem_arbiter;
  logic        clk = 0, reset = 0;
  logic        if_req = 0, ls_req = 0, ls_write = 0, ls_signed = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_wdata = 0, instruction = 0, load_out = 0;
  logic [2:0]  ls_size = 0;
  logic        hready_inst = 1, hready_data = 1, hresp_inst = 0, hresp_data = 0;
  logic        if_gnt, if_valid, if_err, ls_gnt, ls_valid, ls_err;
  logic        HSEL1, HSEL2, muxsel, hwrite, is_signed;
  logic [31:0] if_rdata, ls_rdata, haddr, hwdata;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  int checks = 0, errors = 0;

  typedef struct {
    logic ls, wr; logic [31:0] addr, wdata; logic [2:0] size; logic [31:0] data;
    int waits; logic resp; logic [1:0] e_sel; logic e_err; logic [31:0] e_rdata; int e_vc;
  } vec_t;
  typedef struct { logic wr; logic [31:0] addr, wdata; logic [2:0] size; logic sgn; } req_t;

  ahb_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
    .ls_req(ls_req), .ls_write(ls_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_size(ls_size),
    .ls_signed(ls_signed), .ls_gnt(ls_gnt), .ls_rdata(ls_rdata), .ls_valid(ls_valid), .ls_err(ls_err),
    .HSEL1(HSEL1), .HSEL2(HSEL2), .muxsel(muxsel), .haddr(haddr), .hwdata(hwdata), .hwrite(hwrite),
    .hsize(hsize), .hprot(hprot), .is_signed(is_signed), .instruction(instruction), .load_out(load_out),
    .hready_inst(hready_inst), .hready_data(hready_data), .hresp_inst(hresp_inst), .hresp_data(hresp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got running required finished");
    $fatal(1);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 0; if_req = 0; ls_req = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  function automatic logic [1:0] region(logic [31:0] a);
    if (a < 32'h0000_1000) return 2'd1;
    if (a >= 32'h1000_0000 && a < 32'h1000_1000) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic exp_bad(logic ls, req_t r);
    logic [1:0] rg = region(r.addr);
    if (rg == 2'd0) return 1'b1;
    if (!ls) return 1'b0;
    if (r.wr && rg == 2'd1) return 1'b1;
    return (r.addr % (32'd1 << r.size)) != 0;
  endfunction

  function automatic req_t rand_req(logic ls);
    req_t r;
    logic [31:0] off = $urandom & 32'hFFC;
    case ($urandom_range(0, 5))
      0, 1:    r.addr = off;
      2, 3:    r.addr = 32'h1000_0000 | off;
      4:       r.addr = 32'h2000_0000 | off;
      default: r.addr = $urandom_range(0, 1) != 0 ? 32'h0000_1000 : 32'h0FFF_FFFC;
    endcase
    r.wr    = ls & 1'($urandom_range(0, 1));
    r.size  = ls ? 3'($urandom_range(0, 2)) : 3'd2;
    r.sgn   = ls & 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    if (ls && $urandom_range(0, 3) == 0) r.addr[1:0] = 2'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    vec_t vt[9];
    req_t ir, lr, cur;
    logic if_p, ls_p, w_ls, bad, rdy, rsp, got, last_ls;
    logic [1:0] rg, esel;
    logic [31:0] d;
    int starve, vc;
    logic gq[$];

    vt[0] = '{ls:0, wr:0, addr:32'h10,        wdata:0,            size:2, data:32'h00A00093, waits:0, resp:0, e_sel:2'b10, e_err:0, e_rdata:32'h00A00093, e_vc:3};
    vt[1] = '{ls:1, wr:1, addr:32'h1000_0004, wdata:32'hDEADBEEF, size:2, data:0,            waits:2, resp:0, e_sel:2'b01, e_err:0, e_rdata:0,            e_vc:5};
    vt[2] = '{ls:1, wr:0, addr:32'h2000_0000, wdata:0,            size:2, data:32'h11111111, waits:0, resp:0, e_sel:2'b00, e_err:1, e_rdata:0,            e_vc:3};
    vt[3] = '{ls:1, wr:1, addr:32'h0,         wdata:32'h5A5A5A5A, size:2, data:0,            waits:0, resp:0, e_sel:2'b00, e_err:1, e_rdata:0,            e_vc:3};
    vt[4] = '{ls:1, wr:0, addr:32'h1000_0001, wdata:0,            size:1, data:32'h22222222, waits:0, resp:0, e_sel:2'b00, e_err:1, e_rdata:0,            e_vc:3};
    vt[5] = '{ls:1, wr:0, addr:32'h1000_0008, wdata:0,            size:2, data:32'h12345678, waits:0, resp:1, e_sel:2'b01, e_err:1, e_rdata:32'h12345678, e_vc:3};
    vt[6] = '{ls:1, wr:0, addr:32'h0000_0003, wdata:0,            size:0, data:32'hCAFEF00D, waits:1, resp:0, e_sel:2'b10, e_err:0, e_rdata:32'hCAFEF00D, e_vc:4};
    vt[7] = '{ls:0, wr:0, addr:32'h0000_1000, wdata:0,            size:2, data:32'h33333333, waits:0, resp:0, e_sel:2'b00, e_err:1, e_rdata:0,            e_vc:3};
    vt[8] = '{ls:1, wr:0, addr:32'h1000_0FFE, wdata:0,            size:1, data:32'h0000ABCD, waits:0, resp:0, e_sel:2'b01, e_err:0, e_rdata:32'h0000ABCD, e_vc:3};

    do_reset;
    chk("reset_ctl", {if_gnt, ls_gnt, if_valid, ls_valid, if_err, ls_err, HSEL1, HSEL2, muxsel, hwrite, is_signed, hsize, hprot}, 0);
    chk("reset_data", haddr | hwdata | if_rdata | ls_rdata, 0);

    foreach (vt[i]) begin
      if_req = !vt[i].ls; ls_req = vt[i].ls; if_addr = vt[i].addr; ls_addr = vt[i].addr;
      ls_write = vt[i].wr; ls_wdata = vt[i].wdata; ls_size = vt[i].size; ls_signed = 0;
      instruction = vt[i].e_sel == 2'b10 ? vt[i].data : 32'hBAD0BAD0;
      load_out = vt[i].e_sel == 2'b01 ? vt[i].data : 32'hBAD0BAD0;
      hresp_inst = vt[i].resp; hresp_data = vt[i].resp; hready_inst = 0; hready_data = 0;
      vc = -1;
      for (int c = 1; c <= 12 && vc < 0; c++) begin
        tick;
        if (c == 1) begin
          chk("vec_gnt", {if_gnt, ls_gnt}, vt[i].ls ? 2'b01 : 2'b10);
          chk("vec_hsel", {HSEL1, HSEL2}, vt[i].e_sel);
          chk("vec_hprot", hprot, {3'b000, vt[i].ls});
          chk("vec_haddr", haddr, vt[i].addr);
          chk("vec_hwrite", hwrite, vt[i].wr);
        end
        if (c == 2 && vt[i].wr && vt[i].e_sel != 2'b00) chk("vec_hwdata", hwdata, vt[i].wdata);
        if (if_valid | ls_valid) begin
          vc = c;
          chk("vec_vld", {if_valid, ls_valid}, vt[i].ls ? 2'b01 : 2'b10);
          chk("vec_err", if_err | ls_err, vt[i].e_err);
          chk("vec_rdata", vt[i].ls ? ls_rdata : if_rdata, vt[i].e_rdata);
          if_req = 0; ls_req = 0;
        end
        hready_inst = c >= 2 + vt[i].waits; hready_data = c >= 2 + vt[i].waits;
      end
      chk("vec_vcyc", vc, vt[i].e_vc);
    end

    do_reset;
    starve = 0; last_ls = 0; if_p = 0; ls_p = 0; ir = rand_req(0); lr = rand_req(1);
    for (int n = 0; n < 200; n++) begin
      if (!if_p && $urandom_range(0, 2) != 0) begin if_p = 1; ir = rand_req(0); end
      if (!ls_p && $urandom_range(0, 2) != 0) begin ls_p = 1; lr = rand_req(1); end
      if_req = if_p; if_addr = ir.addr; ls_req = ls_p; ls_write = lr.wr; ls_addr = lr.addr;
      ls_wdata = lr.wdata; ls_size = lr.size; ls_signed = lr.sgn;
      tick;
      if (!if_p && !ls_p) begin
        chk("idle_gnt", {if_gnt, ls_gnt}, 2'b00);
        continue;
      end
`ifdef ARB_ROUND_ROBIN_EN
      w_ls = ls_p && (!if_p || !last_ls);
`else
      w_ls = ls_p && (!if_p || starve < 3);
`endif
      if (!w_ls) starve = 0;
      else if (if_p) starve++;
      last_ls = w_ls;
      cur = w_ls ? lr : ir;
      rg = region(cur.addr);
      bad = exp_bad(w_ls, cur);
      esel = bad ? 2'b00 : (rg == 2'd1 ? 2'b10 : 2'b01);
      chk("rnd_gnt", {if_gnt, ls_gnt}, {!w_ls, w_ls});
      chk("rnd_hsel", {HSEL1, HSEL2, muxsel}, {esel, esel == 2'b01});
      chk("rnd_haddr", haddr, cur.addr);
      chk("rnd_ctl", {hwrite, hsize, hprot, is_signed}, {w_ls & cur.wr, cur.size, 3'b000, w_ls, w_ls & cur.sgn});
      tick;
      chk("rnd_c2_vld", {if_valid, ls_valid}, 2'b00);
      if (!bad) chk("rnd_c2_hsel", {HSEL1, HSEL2}, esel);
      if (!bad && cur.wr) chk("rnd_hwdata", hwdata, cur.wdata);
      got = 0;
      if (bad) begin
        tick;
        chk("rnd_err_vld", {if_valid, ls_valid, if_err | ls_err}, {!w_ls, w_ls, 1'b1});
        chk("rnd_err_rdata", w_ls ? ls_rdata : if_rdata, 0);
      end else
        for (int c = 0; c < 30 && !got; c++) begin
          rdy = c >= 20 || $urandom_range(0, 2) != 0;
          rsp = $urandom_range(0, 7) == 0;
          d = $urandom;
          hready_inst = rg == 2'd1 ? rdy : 1'($urandom_range(0, 1));
          hready_data = rg == 2'd2 ? rdy : 1'($urandom_range(0, 1));
          hresp_inst = rg == 2'd1 ? rsp : 1'b1;
          hresp_data = rg == 2'd2 ? rsp : 1'b1;
          instruction = rg == 2'd1 ? d : ~d;
          load_out = rg == 2'd2 ? d : ~d;
          tick;
          got = rdy;
          chk("rnd_vld", {if_valid, ls_valid}, rdy ? {!w_ls, w_ls} : 2'b00);
          if (rdy) begin
            chk("rnd_err", if_err | ls_err, rsp);
            chk("rnd_rdata", w_ls ? ls_rdata : if_rdata, d);
          end
        end
      if (w_ls) ls_p = 0;
      else if_p = 0;
    end
    if_req = 0; ls_req = 0;
    repeat (3) tick;

    ls_req = 1; ls_write = 0; ls_addr = 32'h1000_0000; ls_size = 2; hready_data = 0; hresp_data = 0;
    tick;
    tick;
    chk("mid_hsel", HSEL2, 1);
    #2 reset = 0;
    #1;
    chk("rst_ctl", {if_gnt, ls_gnt, if_valid, ls_valid, if_err, ls_err, HSEL1, HSEL2, muxsel, hwrite, is_signed, hsize, hprot}, 0);
    chk("rst_haddr", haddr, 0);
    ls_req = 0; hready_data = 1;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("rst_no_vld", {if_valid, ls_valid}, 2'b00);
    end

    if_addr = 0; ls_addr = 32'h1000_0000; ls_write = 0; ls_size = 2;
    hready_inst = 1; hready_data = 1; hresp_inst = 0; hresp_data = 0;
    if_req = 1; ls_req = 1;
    for (int c = 0; c < 80 && gq.size() < 8; c++) begin
      tick;
      chk("gnt_onehot", {1'b0, if_gnt & ls_gnt}, 0);
      if (ls_gnt) gq.push_back(1'b1);
      else if (if_gnt) gq.push_back(1'b0);
    end
    chk("starve_cnt", gq.size(), 8);
    for (int k = 0; k < 8 && k < gq.size(); k++)
`ifdef ARB_ROUND_ROBIN_EN
      chk("arb_order", gq[k], k % 2 == 0);
`else
      chk("arb_order", gq[k], k % 4 != 3);
`endif
    if_req = 0; ls_req = 0;
    repeat (4) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
